// File: rtl/dlx_multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the DLX datapath.
// Drives datapath enables and memory handshakes, with ack timeout and a retire counter.
module dlx_multicycle_seq #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_en,
  input  logic             dec_MemWr,
  input  logic             dec_MemToReg,
  input  logic             dec_Branch,
  input  logic             dec_RegWr,
  input  logic             br_taken,
  output logic             ex_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int unsigned WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = (TIMEOUT > 0) ? WC_W'(TIMEOUT - 1) : '0;

  state_t           r_state;
  state_t           w_next;
  logic [WC_W-1:0]  r_wait;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_retire;
  logic             w_timeout;

  assign w_timeout   = (TIMEOUT > 0) && (r_wait == WC_LAST);
  assign state       = r_state;
  assign err         = r_err;
  assign retired_cnt = r_cnt;

  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    imem_req      = 1'b0;
    ir_en         = 1'b0;
    ex_en         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    rf_we         = 1'b0;
    pc_sel_branch = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_en  = 1'b1;
          w_next = DECODE;
        end else if (w_timeout) begin
          w_next = ERR;
        end
      end
      DECODE: w_next = EXEC;
      EXEC: begin
        ex_en = 1'b1;
        if (dec_MemWr && dec_MemToReg) begin
          w_next = ERR;
        end else if (dec_MemWr || dec_MemToReg) begin
          w_next = MEM;
        end else if (dec_RegWr) begin
          w_next = WB;
        end else begin
          w_retire      = 1'b1;
          pc_sel_branch = dec_Branch && br_taken;
          w_next        = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_MemWr;
        if (dmem_ack) begin
          if (dec_MemToReg) begin
            w_next = WB;
          end else begin
            w_retire = 1'b1;
            w_next   = FETCH;
          end
        end else if (w_timeout) begin
          w_next = ERR;
        end
      end
      WB: begin
        rf_we    = 1'b1;
        w_retire = 1'b1;
        w_next   = FETCH;
      end
      ERR:     w_next = ERR;
      default: w_next = ERR;
    endcase
    pc_en = w_retire;
    // Registered state is already FETCH during reset, so the FETCH request must be masked too.
    if (reset) begin
      imem_req      = 1'b0;
      ir_en         = 1'b0;
      ex_en         = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      rf_we         = 1'b0;
      pc_en         = 1'b0;
      pc_sel_branch = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_wait  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || ((r_state != FETCH) && (r_state != MEM))) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + WC_W'(1);
      end
      if (w_retire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_next == ERR) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
